// File: rtl/jt10_rom_pkg.sv
// Shared definitions for the ADPCM ROM fetch arbiter: FSM encoding, channel
// limit and grant-index width helper.
package jt10_rom_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_t;

  localparam int unsigned NCH_MAX = 8;

  function automatic int unsigned gnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jt10_rom_arb_if.sv
// Single memory read port shared by all ADPCM channels: level request,
// one-cycle acknowledge with data.
interface jt10_rom_arb_if #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 8
);
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic          mem_ack;
  logic [DW-1:0] mem_data;

  modport master (output mem_addr, output mem_req, input mem_ack, input mem_data);
  modport slave  (input mem_addr, input mem_req, output mem_ack, output mem_data);
endinterface

// File: rtl/jt10_rom_arb_rr_pick.sv
// Round-robin picker: first requesting channel after the last grant,
// wrapping modulo NCH. Purely combinational.
module jt10_rr_pick
  import jt10_rom_pkg::*;
#(
  parameter  int unsigned NCH = 2,
  localparam int unsigned GW  = gnt_width(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [GW-1:0]  last,
  output logic [GW-1:0]  gnt,
  output logic           any
);

  int unsigned idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = (32'(last) + (NCH - k)) % NCH;
      if (req[idx]) begin
        gnt = GW'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jt10_rom_arb.sv
// ADPCM ROM fetch arbiter: NCH chip-style read channels with one-entry tag
// caches merged onto one req/ack memory port.
module jt10_rom_arb
  import jt10_rom_pkg::*;
#(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 24,
  parameter int unsigned DW  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*AW-1:0]     ch_addr,
  input  logic [NCH-1:0]        ch_roe_n,
  output logic [NCH*DW-1:0]     ch_data,
  output logic [NCH-1:0]        ch_ok,
  jt10_rom_arb_if.master        mem,
  output logic                  busy
);

  localparam int unsigned GW = gnt_width(NCH);

  arb_state_t       state, state_nx;
  logic [GW-1:0]    gnt, gnt_nx, last_gnt, last_nx, pick;
  logic             any;
  logic [AW-1:0]    addr_nx;
  logic             req_nx;
  logic [NCH-1:0]   pending;
  logic [NCH*AW-1:0] req_addr;
  logic             ack_ok;

  assign ack_ok = (state == ST_WAIT) && mem.mem_ack;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic          roe_q, pend_q, tag_ok_q, ok_q;
    logic [AW-1:0] req_q, tag_q, addr_i;
    logic [DW-1:0] dat_q;
    logic          trig, hit, ack_me;

    assign addr_i = ch_addr[i*AW +: AW];
    assign trig   = !ch_roe_n[i] && (roe_q || addr_i != req_q);
    assign hit    = tag_ok_q && addr_i == tag_q;
    assign ack_me = ack_ok && gnt == GW'(i);

    // A trigger is applied after the ack so it overrides pending/ok on collision.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        roe_q    <= 1'b1;
        pend_q   <= 1'b0;
        tag_ok_q <= 1'b0;
        ok_q     <= 1'b0;
        req_q    <= '0;
        tag_q    <= '0;
        dat_q    <= '0;
      end else begin
        roe_q <= ch_roe_n[i];
        if (ack_me) begin
          dat_q    <= mem.mem_data;
          tag_q    <= mem.mem_addr;
          tag_ok_q <= 1'b1;
          if (req_q == mem.mem_addr) begin
            pend_q <= 1'b0;
            ok_q   <= 1'b1;
          end
        end
        if (trig) begin
          req_q  <= addr_i;
          pend_q <= !hit;
          ok_q   <= hit;
        end
      end
    end

    assign pending[i]               = pend_q;
    assign req_addr[i*AW +: AW]     = req_q;
    assign ch_data[i*DW +: DW]      = dat_q;
    assign ch_ok[i]                 = ok_q;
  end

  jt10_rr_pick #(.NCH(NCH)) u_pick (
    .req  (pending),
    .last (last_gnt),
    .gnt  (pick),
    .any  (any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      gnt          <= '0;
      last_gnt     <= GW'(NCH - 1);
      mem.mem_addr <= '0;
      mem.mem_req  <= 1'b0;
    end else begin
      state        <= state_nx;
      gnt          <= gnt_nx;
      last_gnt     <= last_nx;
      mem.mem_addr <= addr_nx;
      mem.mem_req  <= req_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last_gnt;
    addr_nx  = mem.mem_addr;
    req_nx   = mem.mem_req;
    case (state)
      ST_IDLE: begin
        if (any) begin
          addr_nx  = req_addr[32'(pick)*AW +: AW];
          req_nx   = 1'b1;
          gnt_nx   = pick;
          last_nx  = pick;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem.mem_ack) begin
          req_nx   = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy = (|pending) || (state == ST_WAIT);

endmodule

// File: tb/tb_jt10_rom_arb.sv
// Directed plus randomized bench for jt10_rom_arb with NCH=4; memory contents
// are a fixed function of the address and cache hits are predicted per channel.
module tb_jt10_rom_arb;

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 24;
  localparam int unsigned DW  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_roe_n;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_ok;
  logic              busy;

  jt10_rom_arb_if #(.AW(AW), .DW(DW)) mem_if ();

  jt10_rom_arb #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_addr  (ch_addr),
    .ch_roe_n (ch_roe_n),
    .ch_data  (ch_data),
    .ch_ok    (ch_ok),
    .mem      (mem_if.master),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned dly    = 1;
  int unsigned cnt    = 0;
  bit          auto_mem = 1'b1;
  bit          acked    = 1'b0;
  bit          prev_req = 1'b0;
  logic [AW-1:0] gq[$];
  logic [AW-1:0] mt [NCH];
  bit            mv [NCH];
  bit            rd [NCH];

  function automatic logic [DW-1:0] mem_of(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h87;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_ch(input int unsigned ch, input logic [AW-1:0] a);
    ch_addr[ch*AW +: AW] = a;
  endtask

  function automatic logic [31:0] dat(input int unsigned ch);
    return 32'(ch_data[ch*DW +: DW]);
  endfunction

  // Memory responder: acks dly cycles after a request rises, logs each new request.
  task automatic step_mem();
    if (mem_if.mem_ack) mem_if.mem_ack = 1'b0;
    if (mem_if.mem_req && !prev_req) gq.push_back(mem_if.mem_addr);
    prev_req = mem_if.mem_req;
    if (!mem_if.mem_req) begin
      acked = 1'b0;
      cnt   = 0;
    end else if (auto_mem && !acked) begin
      cnt++;
      if (cnt >= dly) begin
        mem_if.mem_ack  = 1'b1;
        mem_if.mem_data = mem_of(mem_if.mem_addr);
        acked = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step_mem();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy && !mem_if.mem_req) break;
      tick();
    end
    chk("settle_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      if (mem_if.mem_req) break;
      tick();
    end
    chk("req_seen", 32'(mem_if.mem_req), 32'd1);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ch_roe_n = '1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    int unsigned   n0, exp_f;

    rst_n = 1'b0;
    ch_addr = '0;
    ch_roe_n = '1;
    mem_if.mem_ack = 1'b0;
    mem_if.mem_data = '0;
    tick();
    tick();
    chk("rst_mem_req",  32'(mem_if.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("rst_ch_ok",    32'(ch_ok), 32'd0);
    chk("rst_ch_data",  ch_data, 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // single miss, memory acks 2 clk after request
    dly = 2;
    gq.delete();
    set_ch(0, 24'h000123);
    ch_roe_n[0] = 1'b0;
    tick();
    chk("miss_busy",       32'(busy), 32'd1);
    chk("miss_ok_low",     32'(ch_ok[0]), 32'd0);
    chk("miss_no_req_yet", 32'(mem_if.mem_req), 32'd0);
    tick();
    chk("miss_req",  32'(mem_if.mem_req), 32'd1);
    chk("miss_addr", 32'(mem_if.mem_addr), 32'h123);
    tick();
    chk("miss_ok_before_ack", 32'(ch_ok[0]), 32'd0);
    tick();
    chk("miss_ok",      32'(ch_ok[0]), 32'd1);
    chk("miss_data",    dat(0), 32'hA5);
    chk("miss_req_off", 32'(mem_if.mem_req), 32'd0);
    wait_idle();

    // cache hit on same address
    n0 = gq.size();
    ch_roe_n[0] = 1'b1;
    tick();
    chk("hit_ok_roe_high", 32'(ch_ok[0]), 32'd1);
    ch_roe_n[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hit_ok", 32'(ch_ok[0]), 32'd1);
      chk("hit_no_req", 32'(mem_if.mem_req), 32'd0);
    end
    chk("hit_no_fetch", 32'(gq.size()), 32'(n0));
    chk("hit_data", dat(0), 32'hA5);

    // round-robin from a fresh reset, two waves
    do_reset();
    dly = 1;
    for (int w = 0; w < 2; w++) begin
      gq.delete();
      for (int unsigned c = 0; c < NCH; c++) set_ch(c, 24'h001000 + 24'(w * 'h1000) + 24'(c * 16));
      ch_roe_n = '0;
      tick();
      wait_idle();
      chk("rr_count", 32'(gq.size()), 32'(NCH));
      for (int unsigned c = 0; c < NCH; c++) begin
        a = 24'h001000 + 24'(w * 'h1000) + 24'(c * 16);
        if (c < gq.size()) chk("rr_order", 32'(gq[c]), 32'(a));
        chk("rr_ok", 32'(ch_ok[c]), 32'd1);
        chk("rr_data", dat(c), 32'(mem_of(a)));
      end
    end

    // address change while the fetch is in flight
    ch_roe_n = 4'b1101;
    auto_mem = 1'b0;
    gq.delete();
    set_ch(1, 24'h000010);
    tick();
    wait_req();
    chk("chg_addr", 32'(mem_if.mem_addr), 32'h10);
    set_ch(1, 24'h000020);
    tick();
    tick();
    chk("chg_hold_req",  32'(mem_if.mem_req), 32'd1);
    chk("chg_hold_addr", 32'(mem_if.mem_addr), 32'h10);
    mem_if.mem_ack  = 1'b1;
    mem_if.mem_data = mem_of(24'h000010);
    tick();
    chk("chg_ok_low",   32'(ch_ok[1]), 32'd0);
    chk("chg_data_cap", dat(1), 32'(mem_of(24'h000010)));
    chk("chg_busy",     32'(busy), 32'd1);
    auto_mem = 1'b1;
    wait_idle();
    chk("chg_fetches", 32'(gq.size()), 32'd2);
    if (gq.size() == 2) chk("chg_refetch", 32'(gq[1]), 32'h20);
    chk("chg_ok",   32'(ch_ok[1]), 32'd1);
    chk("chg_data", dat(1), 32'(mem_of(24'h000020)));

    // reset during WAIT, then a stray ack
    auto_mem = 1'b0;
    set_ch(2, 24'h000777);
    ch_roe_n[2] = 1'b0;
    tick();
    wait_req();
    rst_n = 1'b0;
    ch_roe_n = '1;
    tick();
    chk("mid_rst_req",  32'(mem_if.mem_req), 32'd0);
    chk("mid_rst_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("mid_rst_ok",   32'(ch_ok), 32'd0);
    chk("mid_rst_data", ch_data, 32'd0);
    rst_n = 1'b1;
    mem_if.mem_ack  = 1'b1;
    mem_if.mem_data = 8'h3C;
    tick();
    tick();
    chk("stray_ok",   32'(ch_ok), 32'd0);
    chk("stray_data", ch_data, 32'd0);
    chk("stray_req",  32'(mem_if.mem_req), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);

    // trigger and ack on the same edge for the granted channel
    gq.delete();
    set_ch(0, 24'h000200);
    ch_roe_n[0] = 1'b0;
    tick();
    wait_req();
    tick();
    mem_if.mem_ack  = 1'b1;
    mem_if.mem_data = mem_of(24'h000200);
    set_ch(0, 24'h000300);
    tick();
    chk("col_ok_low",  32'(ch_ok[0]), 32'd0);
    chk("col_pending", 32'(busy), 32'd1);
    chk("col_req_off", 32'(mem_if.mem_req), 32'd0);
    chk("col_data",    dat(0), 32'(mem_of(24'h000200)));
    tick();
    chk("col_refetch_req",  32'(mem_if.mem_req), 32'd1);
    chk("col_refetch_addr", 32'(mem_if.mem_addr), 32'h300);
    auto_mem = 1'b1;
    wait_idle();
    chk("col_ok",   32'(ch_ok[0]), 32'd1);
    chk("col_data2", dat(0), 32'(mem_of(24'h000300)));

    // randomized reads over a small address pool; hits predicted per channel
    do_reset();
    for (int unsigned c = 0; c < NCH; c++) mv[c] = 1'b0;
    for (int it = 0; it < 30; it++) begin
      ch_roe_n = '1;
      tick();
      dly   = $urandom_range(1, 3);
      n0    = gq.size();
      exp_f = 0;
      for (int unsigned c = 0; c < NCH; c++) begin
        rd[c] = ($urandom_range(0, 3) != 0);
        if (rd[c]) begin
          a = 24'h000040 + 24'($urandom_range(0, 5));
          set_ch(c, a);
          ch_roe_n[c] = 1'b0;
          if (!(mv[c] && mt[c] == a)) exp_f++;
          mt[c] = a;
          mv[c] = 1'b1;
        end
      end
      tick();
      wait_idle();
      chk("rnd_fetches", 32'(gq.size() - n0), 32'(exp_f));
      for (int unsigned c = 0; c < NCH; c++) begin
        if (rd[c]) begin
          chk("rnd_ok", 32'(ch_ok[c]), 32'd1);
          chk("rnd_data", dat(c), 32'(mem_of(mt[c])));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
